// File: rtl/instr_decoder.sv
// Instruction register and decode stage feeding the controller FSM.
// Registers one-hot opcode lines, resolves JPZ/JPN against the flag register, tracks sticky halt.
module instr_decoder #(
  parameter int DATA_W = 8,
  parameter int OPC_W  = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ir_load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              flag_load,
  input  logic [DATA_W-1:0] acc_in,
  output logic              LDA,
  output logic              STA,
  output logic              ADD,
  output logic              SUB,
  output logic              XOR,
  output logic              INC,
  output logic              CLR,
  output logic              JMP,
  output logic              JPZ,
  output logic              JPN,
  output logic              HLT,
  output logic [ADDR_W-1:0] addr_out,
  output logic              z_flag,
  output logic              n_flag,
  output logic              halted,
  output logic              illegal,
  output logic              dec_valid
);

  localparam int NLINES = 11;

  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_STA = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_INC = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_CLR = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_JPZ = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_JPN = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(10);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   ir_p1;
  logic [NLINES-1:0]   lines_p1;
  logic [NLINES-1:0]   lines_d;
  logic                vld_p1;
  logic                z_p1, n_p1;
  logic                accept;
  logic [OPC_W-1:0]    opc_in;

  // Line order (LSB first): LDA STA ADD SUB XOR INC CLR JMP JPZ JPN HLT.
  // Conditional jumps keep their own line and raise JMP only when taken.
  function automatic logic [NLINES-1:0] decode_lines(
    input logic [OPC_W-1:0] opc,
    input logic             z,
    input logic             n
  );
    logic [NLINES-1:0] l;
    l = '0;
    case (opc)
      OP_LDA: l[0] = 1'b1;
      OP_STA: l[1] = 1'b1;
      OP_ADD: l[2] = 1'b1;
      OP_SUB: l[3] = 1'b1;
      OP_XOR: l[4] = 1'b1;
      OP_INC: l[5] = 1'b1;
      OP_CLR: l[6] = 1'b1;
      OP_JMP: l[7] = 1'b1;
      OP_JPZ: begin
        l[8] = 1'b1;
        l[7] = z;
      end
      OP_JPN: begin
        l[9] = 1'b1;
        l[7] = n;
      end
      OP_HLT: l[10] = 1'b1;
      default: l = '0;
    endcase
    return l;
  endfunction

  function automatic logic is_illegal(input logic [OPC_W-1:0] opc);
    return (opc > OP_HLT);
  endfunction

  assign opc_in = data_in[DATA_W-1:DATA_W-OPC_W];
  assign accept = ir_load && (state_q == S_RUN);

  always_comb begin
    state_d = state_q;
    lines_d = decode_lines(opc_in, z_p1, n_p1);
    if (accept && (opc_in == OP_HLT)) begin
      state_d = S_HALT;
    end
  end

  // Stage p1: instruction register, decoded lines and flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_RUN;
      ir_p1    <= '0;
      lines_p1 <= '0;
      vld_p1   <= 1'b0;
      z_p1     <= 1'b0;
      n_p1     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ir_p1    <= data_in;
        lines_p1 <= lines_d;
        vld_p1   <= 1'b1;
      end
      if (flag_load) begin
        z_p1 <= (acc_in == '0);
        n_p1 <= acc_in[DATA_W-1];
      end
    end
  end

  assign LDA       = lines_p1[0];
  assign STA       = lines_p1[1];
  assign ADD       = lines_p1[2];
  assign SUB       = lines_p1[3];
  assign XOR       = lines_p1[4];
  assign INC       = lines_p1[5];
  assign CLR       = lines_p1[6];
  assign JMP       = lines_p1[7];
  assign JPZ       = lines_p1[8];
  assign JPN       = lines_p1[9];
  assign HLT       = lines_p1[10];
  assign addr_out  = ir_p1[ADDR_W-1:0];
  assign z_flag    = z_p1;
  assign n_flag    = n_p1;
  assign halted    = (state_q == S_HALT);
  assign illegal   = vld_p1 && is_illegal(ir_p1[DATA_W-1:DATA_W-OPC_W]);
  assign dec_valid = vld_p1;

endmodule

// File: tb/tb_instr_decoder.sv
// Directed table-driven bench for instr_decoder plus a hand-written halt/illegal sequence.
module tb_instr_decoder;

  logic       clock = 1'b0;
  logic       reset, ir_load, flag_load;
  logic [7:0] data_in, acc_in;
  logic       LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT;
  logic [3:0] addr_out;
  logic       z_flag, n_flag, halted, illegal, dec_valid;

  int checks = 0;
  int passed = 0;

  instr_decoder #(.DATA_W(8), .OPC_W(4), .ADDR_W(4)) dut (
    .clock(clock), .reset(reset), .ir_load(ir_load), .data_in(data_in),
    .flag_load(flag_load), .acc_in(acc_in),
    .LDA(LDA), .STA(STA), .ADD(ADD), .SUB(SUB), .XOR(XOR), .INC(INC),
    .CLR(CLR), .JMP(JMP), .JPZ(JPZ), .JPN(JPN), .HLT(HLT),
    .addr_out(addr_out), .z_flag(z_flag), .n_flag(n_flag),
    .halted(halted), .illegal(illegal), .dec_valid(dec_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        ild;
    logic [7:0]  din;
    logic        fld;
    logic [7:0]  acc;
    logic [10:0] lines;  // {HLT,JPN,JPZ,JMP,CLR,INC,XOR,SUB,ADD,STA,LDA}
    logic [3:0]  addr;
    logic        z, n, h, ill, v;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rst, input logic ild, input logic [7:0] din,
                              input logic fld, input logic [7:0] acc,
                              input logic [10:0] lines, input logic [3:0] addr,
                              input logic z, input logic n, input logic h,
                              input logic ill, input logic v);
    vec_t r;
    r.rst = rst; r.ild = ild; r.din = din; r.fld = fld; r.acc = acc;
    r.lines = lines; r.addr = addr; r.z = z; r.n = n; r.h = h; r.ill = ill; r.v = v;
    return r;
  endfunction

  function automatic logic [10:0] act_lines();
    return {HLT, JPN, JPZ, JMP, CLR, INC, XOR, SUB, ADD, STA, LDA};
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic drive(input logic rst, input logic ild, input logic [7:0] din,
                       input logic fld, input logic [7:0] acc);
    @(negedge clock);
    reset = rst; ir_load = ild; data_in = din; flag_load = fld; acc_in = acc;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string name, input int idx, input vec_t e);
    check({name, "_lines"}, idx, 32'(act_lines()), 32'(e.lines));
    check({name, "_state"}, idx, 32'({addr_out, z_flag, n_flag, halted, illegal, dec_valid}),
          32'({e.addr, e.z, e.n, e.h, e.ill, e.v}));
  endtask

  initial begin
    reset = 1'b0; ir_load = 1'b0; flag_load = 1'b0; data_in = '0; acc_in = '0;

    //          rst ild din    fld acc    lines     addr z  n  h  ill v
    vecs[0]  = mk(1, 0, 8'h00, 0, 8'h00, 11'h000, 4'h0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 8'h2B, 0, 8'h00, 11'h004, 4'hB, 0, 0, 0, 0, 1);
    vecs[2]  = mk(0, 0, 8'h00, 1, 8'h00, 11'h004, 4'hB, 1, 0, 0, 0, 1);
    vecs[3]  = mk(0, 1, 8'h85, 0, 8'h00, 11'h180, 4'h5, 1, 0, 0, 0, 1);
    vecs[4]  = mk(0, 0, 8'h00, 1, 8'h01, 11'h180, 4'h5, 0, 0, 0, 0, 1);
    vecs[5]  = mk(0, 1, 8'h85, 0, 8'h00, 11'h100, 4'h5, 0, 0, 0, 0, 1);
    vecs[6]  = mk(0, 1, 8'h93, 1, 8'h80, 11'h200, 4'h3, 0, 1, 0, 0, 1);
    vecs[7]  = mk(0, 1, 8'h93, 0, 8'h00, 11'h280, 4'h3, 0, 1, 0, 0, 1);
    vecs[8]  = mk(0, 1, 8'hF7, 0, 8'h00, 11'h000, 4'h7, 0, 1, 0, 1, 1);
    vecs[9]  = mk(0, 0, 8'h60, 0, 8'h00, 11'h000, 4'h7, 0, 1, 0, 1, 1);
    vecs[10] = mk(0, 1, 8'h60, 0, 8'h00, 11'h040, 4'h0, 0, 1, 0, 0, 1);
    vecs[11] = mk(0, 1, 8'hA0, 0, 8'h00, 11'h400, 4'h0, 0, 1, 1, 0, 1);
    vecs[12] = mk(0, 1, 8'h10, 0, 8'h00, 11'h400, 4'h0, 0, 1, 1, 0, 1);
    vecs[13] = mk(0, 0, 8'h00, 1, 8'h00, 11'h400, 4'h0, 1, 0, 1, 0, 1);
    vecs[14] = mk(1, 1, 8'h10, 0, 8'h00, 11'h000, 4'h0, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 1, 8'h10, 0, 8'h00, 11'h002, 4'h0, 0, 0, 0, 0, 1);
    vecs[16] = mk(0, 1, 8'h01, 0, 8'h00, 11'h001, 4'h1, 0, 0, 0, 0, 1);
    vecs[17] = mk(0, 1, 8'h5F, 0, 8'h00, 11'h020, 4'hF, 0, 0, 0, 0, 1);
    vecs[18] = mk(0, 1, 8'h40, 0, 8'h00, 11'h010, 4'h0, 0, 0, 0, 0, 1);
    vecs[19] = mk(0, 0, 8'h75, 0, 8'h00, 11'h010, 4'h0, 0, 0, 0, 0, 1);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].ild, vecs[i].din, vecs[i].fld, vecs[i].acc);
      check_all("vec", i, vecs[i]);
    end

    // Illegal opcode cleared by HLT, then a load while halted is ignored
    drive(1, 0, 8'h00, 0, 8'h00);
    check_all("seq", 0, mk(0, 0, 8'h00, 0, 8'h00, 11'h000, 4'h0, 0, 0, 0, 0, 0));
    drive(0, 1, 8'hB3, 0, 8'h00);
    check_all("seq", 1, mk(0, 0, 8'h00, 0, 8'h00, 11'h000, 4'h3, 0, 0, 0, 1, 1));
    drive(0, 1, 8'hA9, 1, 8'hFF);
    check_all("seq", 2, mk(0, 0, 8'h00, 0, 8'h00, 11'h400, 4'h9, 0, 1, 1, 0, 1));
    drive(0, 1, 8'hF0, 0, 8'h00);
    check_all("seq", 3, mk(0, 0, 8'h00, 0, 8'h00, 11'h400, 4'h9, 0, 1, 1, 0, 1));
    drive(0, 0, 8'h00, 0, 8'h00);
    check_all("seq", 4, mk(0, 0, 8'h00, 0, 8'h00, 11'h400, 4'h9, 0, 1, 1, 0, 1));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/instr_decoder.md
Name: instr_decoder

Overview:
- Instruction-register and decode stage directly upstream of the processor controller FSM.
- Latches the instruction byte fetched from memory and registers one-hot opcode lines (LDA..HLT) that the controller samples at its decode state.
- Resolves conditional jumps (JPZ/JPN) against registered accumulator flags and presents the operand address field.
- Holds a sticky halt state and flags undefined opcodes.

Parameters:
- DATA_W, 8, instruction/accumulator width
- OPC_W, 4, opcode field width (instruction bits [DATA_W-1:DATA_W-OPC_W])
- ADDR_W, 4, operand address field width (instruction bits [ADDR_W-1:0]); OPC_W+ADDR_W must equal DATA_W

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ir_load  in  1  strobe from controller fetch state: capture data_in as a new instruction
- data_in  in  DATA_W  memory read data (instruction byte)
- flag_load  in  1  strobe: capture flags from acc_in
- acc_in  in  DATA_W  accumulator value
- LDA,STA,ADD,SUB,XOR,INC,CLR,JMP,JPZ,JPN,HLT  out  1 each  registered decoded opcode lines
- addr_out  out  ADDR_W  registered operand field of the current instruction
- z_flag  out  1  registered zero flag
- n_flag  out  1  registered negative flag
- halted  out  1  sticky halt indicator
- illegal  out  1  current instruction opcode is undefined
- dec_valid  out  1  at least one instruction decoded since reset

Behaviour:
- Reset (sync, active-high, priority over all else): every output 0; IR, flags, halt and valid state cleared.
- Opcode map: 0 LDA, 1 STA, 2 ADD, 3 SUB, 4 XOR, 5 INC, 6 CLR, 7 JMP, 8 JPZ, 9 JPN, A HLT; B–F are illegal.
- Flag register: on an edge with flag_load=1, z_flag <= (acc_in==0) and n_flag <= acc_in[DATA_W-1]. Otherwise the flags hold.
- Decode timing: on an edge with ir_load=1 and halted=0:
  - IR <= data_in
  - addr_out <= data_in[ADDR_W-1:0]
  - all opcode lines are re-registered from data_in's opcode field
  - dec_valid <= 1
  - Latency is one edge. Outputs are valid the cycle after the ir_load cycle and hold until the next accepted load.
- Conditional jump resolution uses the flag register value before the edge. If flag_load and ir_load coincide, the old flags are used.
  - JPZ: JPZ=1 always. JMP=1 only if z_flag=1.
  - JPN: JPN=1 always. JMP=1 only if n_flag=1.
  - Unconditional JMP: JMP=1 only.
  - Every other legal opcode asserts exactly its own line.
- Illegal opcode: all eleven opcode lines are 0 and illegal=1. addr_out is still loaded. illegal clears on the next accepted load of a legal opcode.
- HLT: on the accepted load, HLT=1 and halted=1 on the same edge.
  - While halted=1, ir_load is ignored and all outputs hold (HLT stays 1).
  - flag_load still updates the flags.
  - Only reset clears the halt.
- ir_load=0: IR, opcode lines, addr_out, illegal and dec_valid all hold.
- Reset asserted mid-stream (including while halted): next edge returns to the reset state. The first load after reset decodes normally.
- State machine (halt control): RUN → HALT on an accepted HLT load. HALT → HALT until reset. Reset → RUN.
- Back-to-back ir_load on consecutive cycles is legal. Each edge replaces the decode.

Test Plan:
- Reset, then ir_load with data_in=8'h2B → next cycle ADD=1, addr_out=4'hB, all other lines 0, dec_valid=1, illegal=0.
- flag_load with acc_in=8'h00, then load 8'h85 (JPZ, addr 5) → JPZ=1, JMP=1, z_flag=1. Then flag_load acc_in=8'h01, load 8'h85 → JPZ=1, JMP=0.
- flag_load acc_in=8'h80 in the same cycle as loading 8'h93 (JPN) with n_flag previously 0 → JPN=1, JMP=0 (old flag used), n_flag=1 after the edge.
- Load 8'hA0 → HLT=1, halted=1. Then ir_load with 8'h10 → outputs unchanged (HLT=1, STA=0). Assert reset 1 cycle → all outputs 0, then load 8'h10 → STA=1.
- Load 8'hF7 → illegal=1, all opcode lines 0, addr_out=7. Then load 8'h60 → CLR=1, illegal=0.
- ir_load on three consecutive cycles with 8'h01, 8'h5F, 8'h40 → LDA, INC, XOR each appear exactly one cycle after their load.
